// File: rtl/div_pkg.sv
`default_nettype none
// ============================================================================
// Module      : div_pkg
// Description : Shared definitions for the restoring divider: default
//               operand width, the divider FSM state encoding and the
//               iteration counter width.
// Revision    : 1.0 - initial release
// ============================================================================
package div_pkg;

    localparam int DIV_WIDTH = 4;

    // Counter width needed to count WIDTH iterations. Never below 1 bit,
    // so that a 1- or 2-bit divider still gets a usable counter.
    function automatic int cnt_width(input int w);
        return (w <= 2) ? 1 : $clog2(w);
    endfunction

    localparam int CNT_W = cnt_width(DIV_WIDTH);

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_CALC = 2'b01,
        ST_DONE = 2'b10
    } state_t;

endpackage
`default_nettype wire

// File: rtl/sub_cla.sv
`default_nettype none
// ============================================================================
// Module      : sub_cla
// Description : N-bit carry-lookahead subtractor, D = X - Y. Built as a
//               lookahead adder on X + ~Y with the carry-in tied to 1.
// Ports       : X  in  N  minuend
//               Y  in  N  subtrahend
//               D  out N  difference (modulo 2^N)
//               C  out 1  carry-out, 1 = no borrow (X >= Y)
// Revision    : 1.0 - initial release
// ============================================================================
module sub_cla #(
    parameter int N = 5
) (
    input  logic [N-1:0] X,
    input  logic [N-1:0] Y,
    output logic [N-1:0] D,
    output logic         C
);

    logic [N-1:0] w_p;
    logic [N-1:0] w_g;
    logic [N:0]   w_c;

    assign w_p = X ^ ~Y;
    assign w_g = X & ~Y;

    // Each carry is the flattened lookahead sum
    //   c[i+1] = g[i] | p[i]g[i-1] | ... | p[i]..p[0]c0
    // with c0 = 1, rather than a rippled chain.
    always_comb begin : comb_carry
        logic w_ci;
        logic w_run;
        w_c      = '0;
        w_ci     = 1'b0;
        w_run    = 1'b0;
        w_c[0]   = 1'b1;
        for (int i = 0; i < N; i++) begin
            w_ci  = w_g[i];
            w_run = w_p[i];
            for (int j = i - 1; j >= 0; j--) begin
                w_ci  = w_ci | (w_run & w_g[j]);
                w_run = w_run & w_p[j];
            end
            w_c[i+1] = w_ci | w_run;
        end
    end

    assign D = w_p ^ w_c[N-1:0];
    assign C = w_c[N];

endmodule
`default_nettype wire

// File: rtl/restoring_div.sv
`default_nettype none
// ============================================================================
// Module      : restoring_div
// Description : Multi-cycle unsigned restoring divider, one quotient bit per
//               clock, START/DONE handshake. Division by zero completes after
//               one cycle with Q = all ones, R = A and DZ = 1.
// Ports       : CLK    in  1      rising-edge clock
//               RST_N  in  1      asynchronous active-low reset
//               START  in  1      request, honoured in IDLE or DONE only
//               A, B   in  WIDTH  dividend / divisor, captured on accept
//               BUSY   out 1      high while iterating
//               DONE   out 1      one-cycle completion pulse
//               Q, R   out WIDTH  held quotient / remainder
//               DZ     out 1      divide-by-zero flag for the held result
// Revision    : 1.0 - initial release
// ============================================================================
module restoring_div
    import div_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic             START,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             BUSY,
    output logic             DONE,
    output logic [WIDTH-1:0] Q,
    output logic [WIDTH-1:0] R,
    output logic             DZ
);

    localparam int c_cnt_w = cnt_width(WIDTH);
    localparam logic [c_cnt_w-1:0] c_last = c_cnt_w'(WIDTH - 1);

    state_t             r_state;
    logic [WIDTH-1:0]   r_div;
    logic [WIDTH-1:0]   r_quo;
    logic [WIDTH:0]     r_rem;
    logic [c_cnt_w-1:0] r_cnt;
    logic               r_dz_pend;   // zero divisor accepted, result due next edge
    logic               r_busy;
    logic               r_done;
    logic [WIDTH-1:0]   r_q;
    logic [WIDTH-1:0]   r_r;
    logic               r_dz;

    logic [WIDTH:0]     w_shift;
    logic [WIDTH:0]     w_diff;
    logic               w_carry;
    logic [WIDTH:0]     w_rem_nxt;
    logic [WIDTH-1:0]   w_quo_nxt;
    logic               w_unused_guard;

    // Bring down the next dividend bit into the partial remainder.
    assign w_shift = {r_rem[WIDTH-1:0], r_quo[WIDTH-1]};

    sub_cla #(
        .N (WIDTH + 1)
    ) u_sub_cla (
        .X (w_shift),
        .Y ({1'b0, r_div}),
        .D (w_diff),
        .C (w_carry)
    );

    // Keep the difference only when it did not borrow; otherwise restore.
    assign w_rem_nxt = w_carry ? w_diff : w_shift;
    assign w_quo_nxt = {r_quo[WIDTH-2:0], w_carry};

    // The guard bit of a kept remainder is always zero (rem < div), so it
    // never reaches R; it only widens the trial subtraction.
    assign w_unused_guard = r_rem[WIDTH];

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_state   <= ST_IDLE;
            r_div     <= '0;
            r_quo     <= '0;
            r_rem     <= '0;
            r_cnt     <= '0;
            r_dz_pend <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_q       <= '0;
            r_r       <= '0;
            r_dz      <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE, ST_DONE: begin
                    if ((r_state == ST_DONE) && r_dz_pend) begin
                        // Second cycle of the divide-by-zero path: publish.
                        r_q       <= '1;
                        r_r       <= r_quo;
                        r_dz      <= 1'b1;
                        r_done    <= 1'b1;
                        r_dz_pend <= 1'b0;
                    end else if (START) begin
                        r_div <= B;
                        r_quo <= A;
                        r_rem <= '0;
                        r_cnt <= '0;
                        if (B != '0) begin
                            r_state <= ST_CALC;
                            r_busy  <= 1'b1;
                        end else begin
                            r_state   <= ST_DONE;
                            r_dz_pend <= 1'b1;
                        end
                    end else begin
                        r_state <= ST_IDLE;
                    end
                end
                ST_CALC: begin
                    r_rem <= w_rem_nxt;
                    r_quo <= w_quo_nxt;
                    r_cnt <= r_cnt + 1'b1;
                    if (r_cnt == c_last) begin
                        r_q     <= w_quo_nxt;
                        r_r     <= w_rem_nxt[WIDTH-1:0];
                        r_dz    <= 1'b0;
                        r_done  <= 1'b1;
                        r_busy  <= 1'b0;
                        r_state <= ST_DONE;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign BUSY = r_busy;
    assign DONE = r_done;
    assign Q    = r_q;
    assign R    = r_r;
    assign DZ   = r_dz;

endmodule
`default_nettype wire

// File: doc/restoring_div.md
Name: restoring_div

Overview:
- Multi-cycle unsigned restoring divider. It computes A / B into quotient Q and remainder R, one quotient bit per clock.
- It is the inverse operation of the lookahead adder. Each iteration performs a trial subtraction using that adder style, with B inverted and carry-in forced to 1.
- It sits beside the adder in the arithmetic unit as the first sequential datapath block, driven by a simple START/DONE handshake.

Parameters:
- WIDTH, 4, width of dividend A, divisor B, quotient Q and remainder R.

Ports:
- CLK  input  1  rising-edge clock.
- RST_N  input  1  asynchronous active-low reset.
- START  input  1  request; sampled on rising CLK, accepted only in IDLE or DONE state.
- A  input  WIDTH  dividend; captured on the accepting edge.
- B  input  WIDTH  divisor; captured on the accepting edge.
- BUSY  output  1  high while in CALC.
- DONE  output  1  high for exactly one cycle when Q/R/DZ become valid.
- Q  output  WIDTH  quotient; held until the next completion.
- R  output  WIDTH  remainder; held until the next completion.
- DZ  output  1  divide-by-zero flag for the held result.

Behaviour:
- Reset (RST_N low, asynchronous, any state): state=IDLE, BUSY=0, DONE=0, Q=0, R=0, DZ=0, all internal registers 0. This takes effect immediately, including mid-CALC; the partial result is discarded.
- State IDLE, on START=1 at edge k:
  - Load div=B, quo=A, rem=0 (WIDTH+1 bits), cnt=0.
  - If B!=0, go to CALC; if B==0, go to DONE.
  - A and B may change after edge k without effect.
- State CALC, edges k+1 .. k+WIDTH, one iteration per edge:
  - shifted = {rem[WIDTH-1:0], quo[WIDTH-1]}.
  - diff = shifted + ~{0,div} + 1, computed in WIDTH+1 bits; the carry-out is the no-borrow flag.
  - If carry=1: rem=diff, quo={quo[WIDTH-2:0],1}.
  - If carry=0: rem=shifted (restore), quo={quo[WIDTH-2:0],0}.
  - cnt increments. On the iteration where cnt==WIDTH-1, Q and R are loaded from the final quo and rem[WIDTH-1:0], DZ=0, and the state goes to DONE.
- Latency: DONE is high in the cycle after edge k+WIDTH. BUSY is high in the cycles after edges k .. k+WIDTH-1.
- Divide-by-zero path: at edge k+1, Q=all ones, R=A as captured, DZ=1, state DONE. DONE is high in the cycle after edge k+1.
- State DONE: lasts one cycle with DONE=1.
  - If START=1 at the exiting edge, a new operation is accepted exactly as from IDLE (back-to-back).
  - Otherwise the state goes to IDLE.
- START while in CALC is ignored; operands are not recaptured.
- Q, R and DZ change only at completion or reset. They are never visible mid-calculation.
- Width rule: rem carries one guard bit. R < B always holds when DZ=0.
- Unused state encoding returns to IDLE.

Decomposition:
- Shared package div_pkg:
  - State encoding constants ST_IDLE=2'b00, ST_CALC=2'b01, ST_DONE=2'b10.
  - Default WIDTH.
  - Counter width constant CNT_W = clog2(WIDTH).
- One sub-module, sub_cla:
  - WIDTH+1-bit lookahead subtractor: inputs X, Y; outputs D=X-Y and C (carry-out, 1 = no borrow).
  - Implemented as a lookahead adder with Y inverted and C0=1.
  - Instantiated once in the CALC datapath.

Test Plan:
- 13/3: START at edge k -> DONE high after edge k+4 for one cycle; Q=4, R=1, DZ=0; BUSY=1 for 4 cycles.
- 15/1 -> Q=15, R=0. 3/7 -> Q=0, R=3. 12/12 -> Q=1, R=0. 0/5 -> Q=0, R=0.
- 9/0 -> DONE after edge k+1; Q=15, R=9, DZ=1, BUSY never high. The next op 10/3 then clears DZ: Q=3, R=1.
- START 14/4, then START=1 with A=1, B=1 during CALC -> ignored; result Q=3, R=2.
- RST_N low two cycles into 11/2 -> Q/R/DZ/BUSY/DONE=0 immediately without a clock edge. After release, 12/5 -> Q=2, R=2.
- Back-to-back: START held high across the DONE cycle with 7/2 then 8/3 -> DONE pulses 5 cycles apart; results Q=3, R=1, then Q=2, R=2.
